// File: rtl/lane_elastic_pipe.sv
// lane_elastic_pipe: CHANNELS independent elastic pipelines, DEPTH stages each.
// Each lane has a valid/ready handshake, collapses bubbles, supports a per-lane
// flush and reports how many of its stages currently hold a word.
// Lanes share only clk and rst_n; nothing crosses between them.

module lane_elastic_pipe #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 3,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    input  logic [CHANNELS-1:0]          in_valid,
    output logic [CHANNELS-1:0]          in_ready,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic [CHANNELS-1:0]          out_valid,
    input  logic [CHANNELS-1:0]          out_ready,
    input  logic [CHANNELS-1:0]          flush,
    output logic [CHANNELS*CNT_W-1:0]    occupancy
);

    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_lane
            logic [DEPTH-1:0]  v_r;
            logic [DATA_W-1:0] d_r [DEPTH];
            logic [CNT_W-1:0]  occ_r;
            logic [DEPTH-1:0]  rdy_s;
            logic [DEPTH-1:0]  up_v_s;
            logic [DATA_W-1:0] up_d_s [DEPTH];
            logic              push_s;
            logic              pop_s;

            // Ready chain: stage i may load when it or any stage ahead of it is empty, or the head is draining.
            always_comb begin
                logic acc_s;
                acc_s = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    acc_s = out_ready[c];
                    for (int j = i; j < DEPTH; j++) begin
                        acc_s = acc_s | ~v_r[j];
                    end
                    rdy_s[i] = acc_s;
                end
            end

            // Upstream source of each stage: the producer feeds stage 0, stage i-1 feeds stage i.
            always_comb begin
                up_v_s[0] = in_valid[c];
                up_d_s[0] = in_data[c*DATA_W +: DATA_W];
                for (int i = 1; i < DEPTH; i++) begin
                    up_v_s[i] = v_r[i-1];
                    up_d_s[i] = d_r[i-1];
                end
            end

            // A flushing lane refuses input so the discarded cycle cannot capture a word.
            assign in_ready[c] = rdy_s[0] & ~flush[c];
            assign push_s      = in_valid[c] & in_ready[c];
            assign pop_s       = v_r[DEPTH-1] & out_ready[c] & ~flush[c];

            // Stage registers: valid bits advance on ready; data only moves with a valid word.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    v_r <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        d_r[i] <= '0;
                    end
                end else if (flush[c]) begin
                    v_r <= '0;
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (rdy_s[i]) begin
                            v_r[i] <= up_v_s[i];
                            if (up_v_s[i]) begin
                                d_r[i] <= up_d_s[i];
                            end
                        end
                    end
                end
            end

            // Occupancy counter: tracks pushes minus pops, cleared by flush or reset.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    occ_r <= '0;
                end else if (flush[c]) begin
                    occ_r <= '0;
                end else begin
                    case ({push_s, pop_s})
                        2'b10:   occ_r <= occ_r + CNT_W'(1);
                        2'b01:   occ_r <= occ_r - CNT_W'(1);
                        default: occ_r <= occ_r;
                    endcase
                end
            end

            assign out_valid[c]                  = v_r[DEPTH-1];
            assign out_data[c*DATA_W +: DATA_W]  = d_r[DEPTH-1];
            assign occupancy[c*CNT_W +: CNT_W]   = occ_r;
        end
    endgenerate

endmodule

// File: tb/tb_lane_elastic_pipe.sv
// Testbench for lane_elastic_pipe: directed vector table for the basic scenarios,
// then randomized traffic on all lanes against a word-position reference model.

module tb_lane_elastic_pipe;

    localparam int CH    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                 clk;
    logic                 rst_n;
    logic [CH*DW-1:0]     in_data;
    logic [CH-1:0]        in_valid;
    logic [CH-1:0]        in_ready;
    logic [CH*DW-1:0]     out_data;
    logic [CH-1:0]        out_valid;
    logic [CH-1:0]        out_ready;
    logic [CH-1:0]        flush;
    logic [CH*CW-1:0]     occupancy;

    int n_vec = 0;
    int n_err = 0;

    lane_elastic_pipe #(.CHANNELS(CH), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush), .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rn;
        int         lane;
        logic       v;
        logic [7:0] d;
        logic       o;
        logic       f;
        logic       chk_rdy;
        logic       exp_rdy;
        logic       exp_ov;
        logic [7:0] exp_od;
        int         exp_occ;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rn, int ln, logic v, logic [7:0] d, logic o, logic f,
                                logic cr, logic er, logic eov, logic [7:0] eod, int eoc);
        vec_t t;
        t.rn = rn; t.lane = ln; t.v = v; t.d = d; t.o = o; t.f = f;
        t.chk_rdy = cr; t.exp_rdy = er; t.exp_ov = eov; t.exp_od = eod; t.exp_occ = eoc;
        return t;
    endfunction

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s lane %0d: got %0h expected %0h at %0t", nm, c, act, exp, $time);
        end
    endtask

    // Reference model: each lane is a list of words (oldest first) with their stage position.
    int         m_cnt [CH];
    int         m_pos [CH][DEPTH];
    logic [7:0] m_dat [CH][DEPTH];
    logic [7:0] m_hd  [CH];

    task automatic model_edge(input int c, input logic rn, input logic v, input logic [7:0] d,
                              input logic o, input logic f);
        int   lim;
        logic rdy;
        if (!rn) begin
            m_cnt[c] = 0;
            m_hd[c]  = 8'h00;
        end else if (f) begin
            m_cnt[c] = 0;
        end else begin
            rdy = (m_cnt[c] < DEPTH) || o;
            if (m_cnt[c] > 0 && m_pos[c][0] == DEPTH-1 && o) begin
                for (int k = 1; k < m_cnt[c]; k++) begin
                    m_pos[c][k-1] = m_pos[c][k];
                    m_dat[c][k-1] = m_dat[c][k];
                end
                m_cnt[c]--;
            end
            // Each word steps forward unless the slot ahead stays occupied.
            lim = DEPTH;
            for (int k = 0; k < m_cnt[c]; k++) begin
                if (m_pos[c][k] + 1 < lim) begin
                    m_pos[c][k]++;
                    if (m_pos[c][k] == DEPTH-1) m_hd[c] = m_dat[c][k];
                end
                lim = m_pos[c][k];
            end
            if (v && rdy) begin
                m_pos[c][m_cnt[c]] = 0;
                m_dat[c][m_cnt[c]] = d;
                if (DEPTH == 1) m_hd[c] = d;
                m_cnt[c]++;
            end
        end
    endtask

    task automatic step(input logic rn, input logic [CH-1:0] v, input logic [CH*DW-1:0] d,
                        input logic [CH-1:0] o, input logic [CH-1:0] f);
        rst_n = rn; in_valid = v; in_data = d; out_ready = o; flush = f;
        #1;
        for (int c = 0; c < CH; c++)
            chk("in_ready", c, in_ready[c], f[c] ? 1'b0 : ((m_cnt[c] < DEPTH) || o[c]));
        @(posedge clk);
        for (int c = 0; c < CH; c++) model_edge(c, rn, v[c], d[c*DW +: DW], o[c], f[c]);
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            chk("out_valid", c, out_valid[c], (m_cnt[c] > 0) && (m_pos[c][0] == DEPTH-1));
            chk("out_data", c, out_data[c*DW +: DW], m_hd[c]);
            chk("occupancy", c, occupancy[c*CW +: CW], m_cnt[c]);
        end
    endtask

    initial begin
        logic [CH-1:0]    rv, ro, rf;
        logic [CH*DW-1:0] rd;

        rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = '0; flush = '0;
        for (int c = 0; c < CH; c++) m_cnt[c] = 0;

        // rn, lane, v, d, o, f, chk_rdy, exp_rdy, exp_ov, exp_od, exp_occ
        tbl.push_back(mk(1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0));
        tbl.push_back(mk(1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 0));
        tbl.push_back(mk(1'b1, 0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1));
        tbl.push_back(mk(1'b1, 0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2));
        tbl.push_back(mk(1'b1, 0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 3));
        tbl.push_back(mk(1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 2));
        tbl.push_back(mk(1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 1));
        tbl.push_back(mk(1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33, 0));
        tbl.push_back(mk(1'b1, 1, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1));
        tbl.push_back(mk(1'b1, 1, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2));
        tbl.push_back(mk(1'b1, 1, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 3));
        tbl.push_back(mk(1'b1, 1, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA0, 3));
        tbl.push_back(mk(1'b1, 1, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA1, 3));
        tbl.push_back(mk(1'b1, 1, 1'b1, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA2, 3));
        tbl.push_back(mk(1'b1, 1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA3, 2));
        tbl.push_back(mk(1'b1, 1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA4, 1));
        tbl.push_back(mk(1'b1, 1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA4, 0));
        tbl.push_back(mk(1'b1, 2, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1));
        tbl.push_back(mk(1'b1, 2, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2));
        tbl.push_back(mk(1'b1, 2, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 3));
        tbl.push_back(mk(1'b1, 2, 1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h02, 3));
        tbl.push_back(mk(1'b1, 2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 2));
        tbl.push_back(mk(1'b1, 2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h04, 1));
        tbl.push_back(mk(1'b1, 2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h04, 0));
        tbl.push_back(mk(1'b1, 3, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1));
        tbl.push_back(mk(1'b1, 3, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2));
        tbl.push_back(mk(1'b1, 3, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0));
        tbl.push_back(mk(1'b1, 3, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1));
        tbl.push_back(mk(1'b1, 3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1));
        tbl.push_back(mk(1'b1, 3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 1));
        tbl.push_back(mk(1'b1, 3, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 0));

        @(negedge clk);
        foreach (tbl[i]) begin
            int ln;
            ln = tbl[i].lane;
            rst_n = tbl[i].rn;
            in_valid = '0; in_data = '0; out_ready = '0; flush = '0;
            in_valid[ln] = tbl[i].v;
            in_data[ln*DW +: DW] = tbl[i].d;
            out_ready[ln] = tbl[i].o;
            flush[ln] = tbl[i].f;
            #1;
            if (tbl[i].chk_rdy) chk("tbl_in_ready", ln, in_ready[ln], tbl[i].exp_rdy);
            @(posedge clk);
            @(negedge clk);
            chk("tbl_out_valid", ln, out_valid[ln], tbl[i].exp_ov);
            chk("tbl_out_data", ln, out_data[ln*DW +: DW], tbl[i].exp_od);
            chk("tbl_occupancy", ln, occupancy[ln*CW +: CW], tbl[i].exp_occ);
            if (!tbl[i].rn) begin
                for (int c = 0; c < CH; c++) begin
                    chk("rst_out_valid", c, out_valid[c], 1'b0);
                    chk("rst_out_data", c, out_data[c*DW +: DW], 8'h00);
                    chk("rst_occupancy", c, occupancy[c*CW +: CW], 0);
                end
            end
        end

        // Model-driven phase: start from a reset, partially fill, reset mid-stream.
        step(1'b0, '0, '0, '0, '0);
        step(1'b1, 4'b1111, 32'h44332211, 4'b0000, 4'b0000);
        step(1'b1, 4'b1011, 32'h88776655, 4'b0000, 4'b0000);
        step(1'b1, 4'b0001, 32'h000000C1, 4'b0000, 4'b0000);
        step(1'b0, 4'b1111, 32'hDEADBEEF, 4'b1111, 4'b0000);
        for (int c = 0; c < CH; c++) begin
            chk("midrst_out_valid", c, out_valid[c], 1'b0);
            chk("midrst_out_data", c, out_data[c*DW +: DW], 8'h00);
            chk("midrst_occupancy", c, occupancy[c*CW +: CW], 0);
        end
        step(1'b1, 4'b1111, 32'h5A4B3C2D, 4'b1111, 4'b0000);
        for (int n = 0; n < 4; n++) step(1'b1, '0, '0, 4'b1111, 4'b0000);

        // Randomized independent traffic with occasional flushes on every lane.
        for (int n = 0; n < 1000; n++) begin
            for (int c = 0; c < CH; c++) begin
                rv[c] = ($urandom_range(0, 3) != 0);
                ro[c] = ($urandom_range(0, 2) != 0);
                rf[c] = ($urandom_range(0, 31) == 0);
                rd[c*DW +: DW] = 8'($urandom);
            end
            step(1'b1, rv, rd, ro, rf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
